// File: rtl/urv_writeback_pkg.sv
// Shared definitions for the writeback stage: load width codes, result source codes, FSM encodings.
package urv_defs;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    localparam logic [1:0] RD_SOURCE_ALU      = 2'd0;
    localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'd1;
    localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'd2;
    localparam logic [1:0] RD_SOURCE_CSR      = 2'd3;

    localparam logic [1:0] WB_IDLE       = 2'd0;
    localparam logic [1:0] WB_WAIT_LOAD  = 2'd1;
    localparam logic [1:0] WB_WAIT_STORE = 2'd2;

    // ALU and CSR results share the x_rd_value bus.
    function automatic logic [31:0] select_result(
        input logic [1:0]  source,
        input logic [31:0] value,
        input logic [31:0] shifter,
        input logic [31:0] multiply
    );
        case (source)
            RD_SOURCE_SHIFTER:  return shifter;
            RD_SOURCE_MULTIPLY: return multiply;
            default:            return value;
        endcase
    endfunction

endpackage

// File: rtl/urv_writeback_if.sv
// Pipeline-side bundle of the writeback stage: X-stage qualifiers/results, memory completion, RF write port.
interface urv_writeback_if;

    logic        w_stall_i;
    logic        w_stall_req_o;
    logic        x_valid_i;
    logic        x_load_i;
    logic        x_store_i;
    logic        x_rd_write_i;
    logic [2:0]  x_fun_i;
    logic [4:0]  x_rd_i;
    logic [1:0]  x_rd_source_i;
    logic [31:0] x_rd_value_i;
    logic [31:0] x_rd_shifter_i;
    logic [31:0] x_rd_multiply_i;
    logic [31:0] x_dm_addr_i;
    logic [31:0] dm_data_l_i;
    logic        dm_load_done_i;
    logic        dm_store_done_i;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_write_o;

    modport master (
        output w_stall_i, x_valid_i, x_load_i, x_store_i, x_rd_write_i, x_fun_i, x_rd_i,
               x_rd_source_i, x_rd_value_i, x_rd_shifter_i, x_rd_multiply_i, x_dm_addr_i,
               dm_data_l_i, dm_load_done_i, dm_store_done_i,
        input  w_stall_req_o, rf_rd_o, rf_rd_value_o, rf_rd_write_o
    );

    modport slave (
        input  w_stall_i, x_valid_i, x_load_i, x_store_i, x_rd_write_i, x_fun_i, x_rd_i,
               x_rd_source_i, x_rd_value_i, x_rd_shifter_i, x_rd_multiply_i, x_dm_addr_i,
               dm_data_l_i, dm_load_done_i, dm_store_done_i,
        output w_stall_req_o, rf_rd_o, rf_rd_value_o, rf_rd_write_o
    );

endinterface

// File: rtl/urv_writeback_load_align.sv
// Combinational load data extraction: selects byte/halfword by address and sign/zero-extends.
module urv_load_align
    import urv_defs::*;
(
    input  logic [2:0]  fun_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] value_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = data_i[7:0];
            2'd1:    byte_sel = data_i[15:8];
            2'd2:    byte_sel = data_i[23:16];
            default: byte_sel = data_i[31:24];
        endcase
        half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];
    end

    always_comb begin
        case (fun_i)
            LDST_B:  value_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: value_o = {24'h0, byte_sel};
            LDST_H:  value_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: value_o = {16'h0, half_sel};
            default: value_o = data_i;
        endcase
    end

endmodule

// File: rtl/urv_writeback.sv
// Writeback stage: result mux, load/store completion FSM and register-file write port.
// Optional retired-instruction counter enabled by URV_WB_INSTRET_EN.
module urv_writeback
    import urv_defs::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef URV_WB_INSTRET_EN
    output logic [63:0]       instret_o,
`endif
    urv_writeback_if.slave    wb
);

    logic [1:0]  state_q, state_d;
    logic [4:0]  ld_rd_q;
    logic [2:0]  ld_fun_q;
    logic [1:0]  ld_addr_q;

    logic        accept;
    logic        capture;
    logic        use_load;
    logic        write;
    logic        stall_req;
    logic        retire;
    logic [4:0]  rd_sel;
    logic [2:0]  fun_sel;
    logic [1:0]  addr_sel;
    logic [31:0] load_value;
    logic        unused_addr;

    assign unused_addr = ^wb.x_dm_addr_i[31:2];
    assign accept      = wb.x_valid_i & ~wb.w_stall_i & (state_q == WB_IDLE);

    // Reset gates every combinational effect so it wins over same-cycle done pulses.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        use_load  = 1'b0;
        write     = 1'b0;
        stall_req = 1'b0;
        retire    = 1'b0;
        rd_sel    = wb.x_rd_i;
        fun_sel   = wb.x_fun_i;
        addr_sel  = wb.x_dm_addr_i[1:0];
        case (state_q)
            WB_IDLE: begin
                if (accept) begin
                    if (wb.x_load_i) begin
                        use_load = 1'b1;
                        if (wb.dm_load_done_i) begin
                            write  = 1'b1;
                            retire = 1'b1;
                        end else begin
                            capture   = 1'b1;
                            stall_req = 1'b1;
                            state_d   = WB_WAIT_LOAD;
                        end
                    end else if (wb.x_store_i) begin
                        if (wb.dm_store_done_i) begin
                            retire = 1'b1;
                        end else begin
                            stall_req = 1'b1;
                            state_d   = WB_WAIT_STORE;
                        end
                    end else begin
                        write  = wb.x_rd_write_i;
                        retire = 1'b1;
                    end
                end
            end
            WB_WAIT_LOAD: begin
                use_load = 1'b1;
                rd_sel   = ld_rd_q;
                fun_sel  = ld_fun_q;
                addr_sel = ld_addr_q;
                if (wb.dm_load_done_i) begin
                    write   = 1'b1;
                    retire  = 1'b1;
                    state_d = WB_IDLE;
                end else begin
                    stall_req = 1'b1;
                end
            end
            WB_WAIT_STORE: begin
                if (wb.dm_store_done_i) begin
                    retire  = 1'b1;
                    state_d = WB_IDLE;
                end else begin
                    stall_req = 1'b1;
                end
            end
            default: state_d = WB_IDLE;
        endcase
        if (rst_i) begin
            write     = 1'b0;
            stall_req = 1'b0;
            retire    = 1'b0;
            capture   = 1'b0;
        end
    end

    urv_load_align u_load_align (
        .fun_i   (fun_sel),
        .addr_i  (addr_sel),
        .data_i  (wb.dm_data_l_i),
        .value_o (load_value)
    );

    assign wb.w_stall_req_o = stall_req;
    assign wb.rf_rd_o       = rd_sel;
    assign wb.rf_rd_write_o = write & (rd_sel != 5'd0);
    assign wb.rf_rd_value_o = use_load ? load_value
                            : select_result(wb.x_rd_source_i, wb.x_rd_value_i,
                                            wb.x_rd_shifter_i, wb.x_rd_multiply_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= WB_IDLE;
            ld_rd_q   <= '0;
            ld_fun_q  <= '0;
            ld_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                ld_rd_q   <= wb.x_rd_i;
                ld_fun_q  <= wb.x_fun_i;
                ld_addr_q <= wb.x_dm_addr_i[1:0];
            end
        end
    end

`ifdef URV_WB_INSTRET_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            instret_o <= '0;
        else if (retire)
            instret_o <= instret_o + 64'd1;
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_urv_writeback.sv
// Scoreboard bench for urv_writeback: stimulus queues expected RF writes, a monitor pops and compares.
module tb_urv_writeback;
    import urv_defs::*;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    urv_writeback_if wb ();
`ifdef URV_WB_INSTRET_EN
    logic [63:0] instret;
`endif

    urv_writeback dut (
        .clk_i     (clk),
        .rst_i     (rst),
`ifdef URV_WB_INSTRET_EN
        .instret_o (instret),
`endif
        .wb        (wb)
    );

    wr_t         exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_instret = 64'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_instret(input string name);
`ifdef URV_WB_INSTRET_EN
        check(name, instret, exp_instret);
`else
        if (name.len() == 0) $display("unnamed instret check");
`endif
    endtask

    task automatic clear_x();
        wb.w_stall_i       = 1'b0;
        wb.x_valid_i       = 1'b0;
        wb.x_load_i        = 1'b0;
        wb.x_store_i       = 1'b0;
        wb.x_rd_write_i    = 1'b0;
        wb.x_fun_i         = LDST_L;
        wb.x_rd_i          = 5'd0;
        wb.x_rd_source_i   = RD_SOURCE_ALU;
        wb.x_rd_value_i    = 32'h0;
        wb.x_rd_shifter_i  = 32'h0;
        wb.x_rd_multiply_i = 32'h0;
        wb.x_dm_addr_i     = 32'h0;
        wb.dm_data_l_i     = 32'h0;
        wb.dm_load_done_i  = 1'b0;
        wb.dm_store_done_i = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [4:0] rd, input logic [1:0] src, input logic rdw);
        clear_x();
        wb.x_valid_i       = 1'b1;
        wb.x_rd_write_i    = rdw;
        wb.x_rd_i          = rd;
        wb.x_rd_source_i   = src;
        wb.x_rd_value_i    = 32'h0000_1234;
        wb.x_rd_shifter_i  = 32'hA5A5_0001;
        wb.x_rd_multiply_i = 32'hDEAD_BEEF;
    endtask

    task automatic drive_mem(input logic ld, input logic [4:0] rd, input logic [2:0] fun,
                             input logic [31:0] addr, input logic [31:0] data, input logic done);
        clear_x();
        wb.x_valid_i    = 1'b1;
        wb.x_load_i     = ld;
        wb.x_store_i    = ~ld;
        wb.x_rd_write_i = 1'b1;
        wb.x_rd_i       = rd;
        wb.x_fun_i      = fun;
        wb.x_dm_addr_i  = addr;
        wb.dm_data_l_i  = data;
        wb.x_rd_value_i = 32'h5555_5555;
        if (ld) wb.dm_load_done_i = done; else wb.dm_store_done_i = done;
    endtask

    // Monitor: every RF write must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (wb.rf_rd_write_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_rd", {59'h0, wb.rf_rd_o}, 64'h0);
                    check("unexpected_write", 64'h1, 64'h0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_rd", {59'h0, wb.rf_rd_o}, {59'h0, e.rd});
                    check("wr_value", {32'h0, wb.rf_rd_value_o}, {32'h0, e.value});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_x();
        rst = 1'b1;
        #1;
        next();
        @(negedge clk);
        check("reset_stall_req", {63'h0, wb.w_stall_req_o}, 64'h0);
        check("reset_rf_write", {63'h0, wb.rf_rd_write_o}, 64'h0);
        check_instret("reset_instret");
        next();
        rst = 1'b0;

        // Non-memory ops: one per result source, rd=0, rd_write=0, and a stalled op.
        drive_op(5'd5, RD_SOURCE_ALU, 1'b1);
        exp_q.push_back('{rd: 5'd5, value: 32'h0000_1234});
        exp_instret++;
        @(negedge clk); check("alu_stall_req", {63'h0, wb.w_stall_req_o}, 64'h0);
        next();
        drive_op(5'd7, RD_SOURCE_SHIFTER, 1'b1);
        exp_q.push_back('{rd: 5'd7, value: 32'hA5A5_0001});
        exp_instret++;
        next();
        drive_op(5'd8, RD_SOURCE_MULTIPLY, 1'b1);
        exp_q.push_back('{rd: 5'd8, value: 32'hDEAD_BEEF});
        exp_instret++;
        next();
        drive_op(5'd9, RD_SOURCE_CSR, 1'b1);
        exp_q.push_back('{rd: 5'd9, value: 32'h0000_1234});
        exp_instret++;
        next();
        drive_op(5'd0, RD_SOURCE_ALU, 1'b1);
        exp_instret++;
        @(negedge clk); check("rd0_no_write", {63'h0, wb.rf_rd_write_o}, 64'h0);
        next();
        drive_op(5'd11, RD_SOURCE_ALU, 1'b0);
        exp_instret++;
        next();
        drive_op(5'd12, RD_SOURCE_ALU, 1'b1);
        wb.w_stall_i = 1'b1;
        @(negedge clk); check("stalled_no_write", {63'h0, wb.rf_rd_write_o}, 64'h0);
        next();
        clear_x();
        @(negedge clk); check_instret("instret_after_ops");
        next();

        // LB at addr 3, done on the fourth cycle: three stall cycles.
        drive_mem(1'b1, 5'd10, LDST_B, 32'h0000_1003, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("lb_stall_req", {63'h0, wb.w_stall_req_o}, 64'h1);
            next();
            clear_x();
            wb.x_rd_i  = 5'd21;
            wb.x_fun_i = LDST_HU;
        end
        wb.dm_data_l_i    = 32'h80FF_FF00;
        wb.dm_load_done_i = 1'b1;
        exp_q.push_back('{rd: 5'd10, value: 32'hFFFF_FF80});
        exp_instret++;
        @(negedge clk); check("lb_done_stall_req", {63'h0, wb.w_stall_req_o}, 64'h0);
        next();
        clear_x();

        // Same-cycle loads: LHU, LH sign-extend, LBU, rd=0.
        drive_mem(1'b1, 5'd13, LDST_HU, 32'h0000_0002, 32'hBEEF_0000, 1'b1);
        exp_q.push_back('{rd: 5'd13, value: 32'h0000_BEEF});
        exp_instret++;
        @(negedge clk); check("lhu_stall_req", {63'h0, wb.w_stall_req_o}, 64'h0);
        next();
        drive_mem(1'b1, 5'd14, LDST_H, 32'h0000_0000, 32'h0000_8001, 1'b1);
        exp_q.push_back('{rd: 5'd14, value: 32'hFFFF_8001});
        exp_instret++;
        next();
        drive_mem(1'b1, 5'd15, LDST_BU, 32'h0000_0001, 32'h0000_9A00, 1'b1);
        exp_q.push_back('{rd: 5'd15, value: 32'h0000_009A});
        exp_instret++;
        next();
        drive_mem(1'b1, 5'd0, LDST_L, 32'h0000_0000, 32'h1111_2222, 1'b1);
        exp_instret++;
        next();

        // LW waiting one cycle.
        drive_mem(1'b1, 5'd16, LDST_L, 32'h0000_0004, 32'h0, 1'b0);
        next();
        clear_x();
        wb.dm_data_l_i    = 32'hCAFE_F00D;
        wb.dm_load_done_i = 1'b1;
        exp_q.push_back('{rd: 5'd16, value: 32'hCAFE_F00D});
        exp_instret++;
        next();
        clear_x();

        // Store completing after 2 cycles: two stall cycles, no RF write.
        drive_mem(1'b0, 5'd3, LDST_L, 32'h0000_0008, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); check("st_stall_req", {63'h0, wb.w_stall_req_o}, 64'h1);
            next();
            clear_x();
        end
        wb.dm_store_done_i = 1'b1;
        exp_instret++;
        @(negedge clk); check("st_done_stall_req", {63'h0, wb.w_stall_req_o}, 64'h0);
        next();
        drive_mem(1'b0, 5'd4, LDST_L, 32'h0000_000C, 32'h0, 1'b1);
        exp_instret++;
        @(negedge clk); check("st_same_stall_req", {63'h0, wb.w_stall_req_o}, 64'h0);
        next();

        // Stray done pulses in IDLE are ignored.
        clear_x();
        wb.dm_load_done_i  = 1'b1;
        wb.dm_store_done_i = 1'b1;
        wb.x_rd_i          = 5'd6;
        @(negedge clk); check("stray_stall_req", {63'h0, wb.w_stall_req_o}, 64'h0);
        next();
        clear_x();
        @(negedge clk); check_instret("instret_after_mem");
        next();

        // Reset in WAIT_LOAD abandons the load.
        drive_mem(1'b1, 5'd17, LDST_L, 32'h0, 32'h0, 1'b0);
        next();
        clear_x();
        @(negedge clk); check("wait_load_stall_req", {63'h0, wb.w_stall_req_o}, 64'h1);
        next();
        rst = 1'b1;
        wb.dm_load_done_i = 1'b1;
        wb.dm_data_l_i    = 32'h7777_7777;
        exp_instret = 64'd0;
        @(negedge clk); check("rst_stall_req", {63'h0, wb.w_stall_req_o}, 64'h0);
        next();
        rst = 1'b0;
        @(negedge clk); check("post_rst_stall_req", {63'h0, wb.w_stall_req_o}, 64'h0);
        check_instret("post_rst_instret");
        next();
        clear_x();
        drive_op(5'd1, RD_SOURCE_ALU, 1'b1);
        exp_q.push_back('{rd: 5'd1, value: 32'h0000_1234});
        exp_instret++;
        next();
        clear_x();
        @(negedge clk); check_instret("final_instret");
        next();
        @(negedge clk);
        check("pending_writes", exp_q.size(), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
